// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver:
// segment patterns (bit0=a .. bit6=g) and FSM state encodings.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOAD    = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_seg7.sv
// Combinational BCD digit to 7-segment decoder.
// Codes above 9 decode to a blank digit.
module bcd_digit_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-digit 7-segment driver: serial binary-to-BCD converter,
// display register, digit scanner, blanking and overflow dash.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int BIN_W          = 14,
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BIN_W-1:0]  val_i,
  input  logic              val_valid_i,
  output logic              val_ready_o,
  input  logic              blank_lz_i,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] dig_o,
  output logic              ovf_o
);

  localparam int DISP_W = 4 * DIGITS;
  localparam int ACC_W  = DISP_W + 4;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int CNT_W  = $clog2(BIN_W + 1);

  localparam logic [6:0]        SEG_INV = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic [DIGITS-1:0] DIG_INV = {DIGITS{DIG_ACTIVE_LOW != 0}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BIN_W-1:0]    r_shreg;
  logic [ACC_W-1:0]    r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_blank_cap;
  logic [DISP_W-1:0]   r_disp;
  logic                r_ovf;
  logic                r_blank;
  logic [PRE_W-1:0]    r_pre;
  logic [IDX_W-1:0]    r_idx;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_dig;

  logic [DISP_W-1:0]   w_adj;
  logic [DISP_W-1:0]   w_disp_nxt;
  logic                w_ovf_nxt;
  logic                w_blank_nxt;
  logic [3:0]          w_nib;
  logic [IDX_W-1:0]    w_msd;
  logic [6:0]          w_dec;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_onehot;

  assign val_ready_o = (r_state == ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (val_valid_i) w_state_nxt = ST_CONVERT;
      ST_CONVERT: if (r_cnt == CNT_W'(BIN_W - 1)) w_state_nxt = ST_LOAD;
      ST_LOAD:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // The top nibble never reaches 5 given BIN_W <= 3*DIGITS+3, so it skips add-3.
  always_comb begin
    w_adj = r_bcd[DISP_W-1:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shreg     <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_blank_cap <= 1'b0;
      r_disp      <= '0;
      r_ovf       <= 1'b0;
      r_blank     <= 1'b0;
    end else begin
      if (val_ready_o && val_valid_i) begin
        r_shreg     <= val_i;
        r_blank_cap <= blank_lz_i;
        r_bcd       <= '0;
        r_cnt       <= '0;
      end
      if (r_state == ST_CONVERT) begin
        r_bcd   <= {r_bcd[ACC_W-2 -: 3], w_adj, r_shreg[BIN_W-1]};
        r_shreg <= r_shreg << 1;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (r_state == ST_LOAD) begin
        r_disp  <= w_disp_nxt;
        r_ovf   <= w_ovf_nxt;
        r_blank <= w_blank_nxt;
      end
    end
  end

  // Look-ahead values let seg_o show the new result on the edge that loads it.
  assign w_disp_nxt  = (r_state == ST_LOAD) ? r_bcd[DISP_W-1:0] : r_disp;
  assign w_ovf_nxt   = (r_state == ST_LOAD) ? (r_bcd[ACC_W-1 -: 4] != 4'd0) : r_ovf;
  assign w_blank_nxt = (r_state == ST_LOAD) ? r_blank_cap : r_blank;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_W'(REFRESH_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_comb begin
    w_nib = 4'd0;
    w_msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) w_nib = w_disp_nxt[4*i +: 4];
      if (w_disp_nxt[4*i +: 4] != 4'd0) w_msd = IDX_W'(i);
    end
  end

  bcd_digit_seg7 u_dec (
    .i_bcd (w_nib),
    .o_seg (w_dec)
  );

  always_comb begin
    w_seg = w_dec;
    if (w_ovf_nxt)                         w_seg = SEG_DASH;
    else if (w_blank_nxt && r_idx > w_msd) w_seg = SEG_BLANK;
  end

  assign w_onehot = DIGITS'(1) << r_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_seg <= SEG_INV;
      r_dig <= DIG_INV;
    end else begin
      r_seg <= w_seg ^ SEG_INV;
      r_dig <= w_onehot ^ DIG_INV;
    end
  end

  assign seg_o = r_seg;
  assign dig_o = r_dig;
  assign ovf_o = r_ovf;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed vector table,
// corner sequences and random values against a behavioural display model.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int RD     = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [13:0] val_i = '0;
  logic        val_valid_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic        val_ready_o;
  logic [6:0]  seg_o;
  logic [3:0]  dig_o;
  logic        ovf_o;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_DIV(RD),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .val_i(val_i),
    .val_valid_i(val_valid_i), .val_ready_o(val_ready_o),
    .blank_lz_i(blank_lz_i), .seg_o(seg_o), .dig_o(dig_o), .ovf_o(ovf_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference model: shown value changes BIN_W+1 edges after the handshake edge.
  int unsigned m_val = 0, p_val = 0;
  bit          m_bl = 0, p_bl = 0, pend = 0;
  int          cd = 0, cnt = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst_i) begin
      m_val = 0; m_bl = 0; pend = 0; cd = 0; cnt = 0;
    end else begin
      cnt++;
      if (pend) begin
        cd--;
        if (cd == 0) begin
          m_val = p_val; m_bl = p_bl; pend = 0;
        end
      end else if (val_valid_i) begin
        p_val = val_i; p_bl = blank_lz_i; pend = 1; cd = BIN_W + 1;
      end
    end
  end

  function automatic logic [6:0] model_seg(input int idx);
    int unsigned p = 1;
    for (int k = 0; k < idx; k++) p *= 10;
    if (m_val > 9999) return 7'b1000000;
    if (m_bl && idx > 0 && m_val < p) return 7'b0000000;
    return dec(int'((m_val / p) % 10));
  endfunction

  always @(negedge clk) begin
    int         idx;
    logic [3:0] ed;
    logic [6:0] es;
    if (chk_en) begin
      if (cnt == 0) begin
        ed = 4'd0; es = 7'd0;
      end else begin
        idx = ((cnt - 1) / RD) % DIGITS;
        ed = 4'(1 << idx);
        es = model_seg(idx);
      end
      chk("scan_dig", 32'(dig_o), 32'(ed));
      chk("scan_seg", 32'(seg_o), 32'(es));
      chk("scan_ready", 32'(val_ready_o), 32'(!pend));
      chk("scan_ovf", 32'(ovf_o), 32'(m_val > 9999));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!val_ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!val_ready_o) chk("ready_timeout", 32'(val_ready_o), 32'd1);
  endtask

  task automatic send(input int unsigned v, input bit b, output int low);
    wait_ready();
    val_valid_i = 1'b1; val_i = 14'(v); blank_lz_i = b;
    @(negedge clk);
    val_valid_i = 1'b0;
    low = 0;
    while (!val_ready_o && low < 100) begin
      low++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int unsigned     v;
    bit              bl;
    bit              ovf;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          low, k;
    int unsigned cap;
    vecs[0] = '{1234,  1'b0, 1'b0, {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}};
    vecs[1] = '{7,     1'b1, 1'b0, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000111}};
    vecs[2] = '{0,     1'b1, 1'b0, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}};
    vecs[3] = '{12000, 1'b0, 1'b1, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    vecs[4] = '{9999,  1'b0, 1'b0, {7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111}};

    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_seg", 32'(seg_o), 32'd0);
    chk("rst_dig", 32'(dig_o), 32'd0);
    chk("rst_ready", 32'(val_ready_o), 32'd1);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_dig", 32'(dig_o), 32'd1);
    chk("post_rst_seg", 32'(seg_o), 32'h3f);

    foreach (vecs[i]) begin
      send(vecs[i].v, vecs[i].bl, low);
      chk("busy_cycles", 32'(low), 32'(BIN_W + 1));
      repeat (RD) @(negedge clk);
      for (int c = 0; c < DIGITS * RD; c++) begin
        k = -1;
        for (int j = 0; j < DIGITS; j++) if (dig_o == 4'(1 << j)) k = j;
        chk("tbl_onehot", 32'($onehot(dig_o)), 32'd1);
        if (k >= 0) chk("tbl_seg", 32'(seg_o), 32'(vecs[i].seg[k]));
        chk("tbl_ovf", 32'(ovf_o), 32'(vecs[i].ovf));
        @(negedge clk);
      end
    end

    // Valid held high with changing data during conversion.
    wait_ready();
    cap = 4321;
    val_valid_i = 1'b1; val_i = 14'(cap); blank_lz_i = 1'b0;
    repeat (BIN_W + 1) begin
      @(negedge clk);
      val_i = 14'($urandom_range(0, 16383));
    end
    @(negedge clk);
    val_valid_i = 1'b0;
    k = 0;
    while (dig_o != 4'b0001 && k < 40) begin
      k++;
      @(negedge clk);
    end
    chk("hold_digit0", 32'(seg_o), 32'(dec(int'(cap % 10))));
    @(negedge clk);

    // Reset in CONVERT cycle 5 aborts the conversion.
    wait_ready();
    val_valid_i = 1'b1; val_i = 14'd8765; blank_lz_i = 1'b0;
    @(negedge clk);
    val_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(val_ready_o), 32'd1);
    chk("abort_seg", 32'(seg_o), 32'd0);
    chk("abort_dig", 32'(dig_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("abort_disp0", 32'(seg_o), 32'h3f);
    chk("abort_ovf", 32'(ovf_o), 32'd0);
    repeat (3 * DIGITS * RD) @(negedge clk);

    for (int r = 0; r < 25; r++) begin
      send($urandom_range(0, 16383), 1'($urandom_range(0, 1)), low);
      chk("rnd_busy", 32'(low), 32'(BIN_W + 1));
      repeat (DIGITS * RD + $urandom_range(0, 5)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multi-digit 7-segment display driver: accepts a binary value over a valid/ready handshake and converts it to BCD sequentially (shift-add-3, one bit per cycle). It holds the result in a display register and time-multiplexes the digits onto one shared segment bus with a one-hot digit enable. It adds leading-zero blanking and overflow indication. It sits between the design's binary counters and the board's common-cathode or common-anode multi-digit display.

## Interface
- `DIGITS`, 4: number of display digits, ≥1.
- `BIN_W`, 14: input value width; constraint `BIN_W ≤ 3*DIGITS+3`.
- `REFRESH_DIV`, 1000: clock cycles each digit stays enabled, ≥2.
- `SEG_ACTIVE_LOW`, 0: 1 inverts `seg_o`.
- `DIG_ACTIVE_LOW`, 0: 1 inverts `dig_o`.

Ports:
- `clk_i` input 1: single clock.
- `rst_i` input 1: reset, synchronous and active-high.
- `val_i` input BIN_W: binary value to display.
- `val_valid_i` input 1: `val_i` is valid.
- `val_ready_o` output 1: block can accept a value.
- `blank_lz_i` input 1: blank leading zeros; sampled at handshake.
- `seg_o` output 7: segments; bit0=a … bit6=g.
- `dig_o` output DIGITS: one-hot digit enable; bit0 = least significant digit.
- `ovf_o` output 1: displayed value exceeds `10^DIGITS-1`.

## Operation
- **FSM states:** IDLE, CONVERT, LOAD.
  - IDLE: `val_ready_o=1`. On `val_valid_i`, capture `val_i` and `blank_lz_i`, clear the BCD accumulator (DIGITS+1 nibbles), clear the bit counter, then go to CONVERT.
  - CONVERT: each cycle, add 3 to every nibble ≥5, then shift left one bit, taking the input MSB first. After exactly BIN_W cycles, go to LOAD.
  - LOAD: copy the low DIGITS nibbles into the display register; `ovf_o` = top nibble ≠ 0; latch the blank flag. Then go to IDLE.
- `val_ready_o` is combinational: it equals (state == IDLE). `val_valid_i` outside IDLE is ignored.
- The display register changes only in LOAD. The old value stays displayed throughout CONVERT, with no glitch.
- **Scan:**
  - The prescaler counts 0..REFRESH_DIV-1.
  - On wrap, the digit index increments 0..DIGITS-1 and then wraps to 0.
  - The scan runs continuously and independently of the FSM.
- **Segment select:**
  - If overflow, every digit shows a dash (g only).
  - If blank is active and the digit index is greater than the index of the most-significant nonzero digit, the digit is blank (0000000).
  - Digit 0 is never blanked, so the value 0 shows "0".
  - Otherwise the BCD digit is decoded to segments: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Nibbles >9 cannot occur; the decoder default is blank.
- Blanked digits still get their `dig_o` slot, so scan timing stays uniform.
- Polarity inversion is applied last, at the output registers.

## Timing
- **Reset values:**
  - FSM = IDLE, so `val_ready_o=1`.
  - Display register = 0, `ovf_o=0`, blank flag = 0.
  - Prescaler and digit index = 0.
  - `seg_o` and `dig_o` are at their inactive levels: all 0, or all 1 when the corresponding ACTIVE_LOW parameter is set.
- `seg_o` and `dig_o` are registered. The cycle after reset deasserts, they show digit 0 with `dig_o` one-hot bit0.
- **Latency:**
  - Handshake at cycle 0; CONVERT occupies cycles 1..BIN_W; LOAD is cycle BIN_W+1.
  - The display register and `ovf_o` update at the end of LOAD. `seg_o` reflects the new value from cycle BIN_W+2 for the currently scanned digit.
  - `val_ready_o` is high again in cycle BIN_W+2.
- Throughput: one value per BIN_W+2 cycles.
- `dig_o` changes exactly on prescaler wrap. `seg_o` changes on the same edge as `dig_o`. A full frame is `DIGITS*REFRESH_DIV` cycles.
- Reset asserted mid-CONVERT or mid-LOAD aborts the conversion. All state returns to reset values on the next edge.
- A handshake in the same cycle as reset is discarded.

## Structure
- Shared include `seg7_pkg` holds:
  - segment constants SEG_0..SEG_9, SEG_DASH=7'b1000000, SEG_BLANK=7'b0000000;
  - FSM state encodings ST_IDLE/ST_CONVERT/ST_LOAD.
- Sub-module `bcd_digit_seg7`: combinational 4-bit → 7-segment decoder using the package constants. It is instantiated once, on the digit muxed by the scan index.
- Converter, FSM, prescaler and scan are all in the top module.

## Test plan
Bench parameters: DIGITS=4, BIN_W=14, REFRESH_DIV=4, active-high.
- Reset: hold `rst_i` 3 cycles → `seg_o`=0, `dig_o`=0, `val_ready_o`=1, `ovf_o`=0. Cycle after release → `dig_o`=0001, `seg_o`=0111111.
- Send 1234, blanking off → ready low for exactly 15 cycles. Then per frame: dig 0001/1100110, 0010/1001111, 0100/1011011, 1000/0000110, each held 4 cycles.
- Send 7, blanking on → dig0 shows 0000111. Digits 1-3 show 0000000 while `dig_o` keeps stepping. Send 0 with blanking → dig0 shows 0111111.
- Send 12000 → `ovf_o`=1 and all four digits show 1000000. Then send 9999 → `ovf_o`=0 and all digits show 1101111.
- Hold `val_valid_i` high with changing `val_i` during CONVERT → only the value captured at the handshake is displayed. The old value persists on `seg_o` until LOAD.
- Assert `rst_i` in CONVERT cycle 5 → the next cycle is IDLE with ready=1 and the display register 0. The aborted value never appears.
